fetch_mem_responder: RTL and testbench
======================================

Name: fetch_mem_responder

Overview:
- Memory-side responder for the CPU's instruction fetch and data access interface. This is the other end of the bus the CPU drives during S_FetchPCtoMEM and its load/store states.
- Latches one request, inserts a parameterised number of wait states, then performs the read or write and acknowledges with a four-phase Req/Ack handshake.
- Holds a DataWidth x 2^AddrWidth word array and sits beside the CPU in the top-level system.

Parameters:
- DataWidth, 16, word width of memory and data buses.
- AddrWidth, 8, word-address width; the array holds 2^AddrWidth words.
- WaitStates, 2, extra cycles before Ack; legal range 0..15.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req  input  1  request from CPU; held high until Ack is seen.
- WrEn  input  1  1 = write, 0 = read; sampled with Req.
- Addr  input  AddrWidth  word address; sampled with Req.
- DataIn  input  DataWidth  write data; sampled with Req.
- DataOut  output  DataWidth  read data; valid while Ack is high, then held.
- Ack  output  1  transaction complete.
- Busy  output  1  high whenever the block is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears state to IDLE, wait counter to 0, Ack=0, Busy=0, DataOut=0.
  - Discards any pending request.
  - Memory array contents are NOT reset and are preserved across reset.
- State machine IDLE, WAIT, ACK. Busy = (state != IDLE). Ack = (state == ACK). Both are registered-state decodes and glitch-free.
- IDLE:
  - On an edge with Req=1, latch Addr, WrEn and DataIn; load Cnt=WaitStates.
  - If WaitStates==0, go to ACK; otherwise go to WAIT.
  - Req=0 keeps the block in IDLE.
- WAIT:
  - Req=0 on an edge aborts: go to IDLE, perform no memory access, never raise Ack, leave DataOut unchanged.
  - Else if Cnt==1, go to ACK; else decrement Cnt.
- Access on the edge that enters ACK:
  - Write: mem[latched Addr] <= latched DataIn. DataOut is unchanged.
  - Read: DataOut <= mem[latched Addr].
- Latency: Ack is visible after the (WaitStates+1)-th rising edge, counting the first edge that samples Req=1 as edge 1. WaitStates=2 gives Ack after edge 3.
- ACK:
  - Ack stays high while Req=1.
  - The first edge with Req=0 returns to IDLE and Ack falls.
  - A new request needs Req low for at least one edge; Req held high never starts a second transaction.
- Changes on Addr, WrEn or DataIn after the sampling edge are ignored until the next IDLE sample.
- Address covers the full array; 'hFF with AddrWidth=8 is the last valid word. No wrap or overflow logic is needed.
- DataOut holds the last read value across writes, aborts and idle periods; only reset clears it.
- Reset asserted in WAIT or ACK forces IDLE immediately: Ack and Busy drop asynchronously. A write not yet committed is lost; one already committed stays.

Test Plan:
1. Write then read, WaitStates=2:
   - Req=1, WrEn=1, Addr='h10, DataIn='hA55A at edge E1 -> Busy=1 after E1, Ack=1 after E3.
   - Drop Req -> Ack=0, Busy=0 after the next edge.
   - Then read 'h10 -> DataOut='hA55A with Ack after 3 edges.
2. Zero-wait instance (WaitStates=0):
   - Write 'h1234 to 'h00, then read 'h00 -> Ack after the first sampling edge, DataOut='h1234.
3. Boundary address:
   - Write 'hBEEF to 'hFF and 'h0001 to 'h00, read 'hFF -> DataOut='hBEEF (no aliasing with 'h00).
4. Abort:
   - Start a write of 'hDEAD to 'h20, drop Req after E2 (in WAIT) -> Ack never rises, state returns to IDLE.
   - Then read 'h20 -> the old contents are returned, not 'hDEAD.
5. Reset mid-operation:
   - Assert Reset in WAIT of a write -> Ack=0, Busy=0, DataOut=0 immediately, without a clock edge.
   - After release, the target word is unchanged and previously written words are intact.
6. Held Req and input changes:
   - Keep Req=1 for 5 edges after Ack -> Ack stays 1 and no second access occurs.
   - Change Addr during WAIT -> the original latched address is used.

Source files
------------

// File: rtl/fetch_mem_responder_if.sv
// Bus between the CPU fetch/load-store logic and the memory responder.
//
// Handshake (four-phase Req/Ack): the master raises Req with WrEn, Addr
// and DataIn valid and holds Req high until it sees Ack. The responder
// samples the request on the first rising edge with Req=1 and raises Ack
// once the access is done. Ack stays high while Req stays high; the
// master then drops Req and the responder drops Ack on the next edge.
// Req must be seen low on at least one edge before a new request starts.
// Dropping Req before Ack aborts the request with no memory access.
interface fetch_mem_responder_if #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 8
);
    logic                 Req;
    logic                 WrEn;
    logic [AddrWidth-1:0] Addr;
    logic [DataWidth-1:0] DataIn;
    logic [DataWidth-1:0] DataOut;
    logic                 Ack;
    logic                 Busy;

    modport master (
        output Req, WrEn, Addr, DataIn,
        input  DataOut, Ack, Busy
    );

    modport slave (
        input  Req, WrEn, Addr, DataIn,
        output DataOut, Ack, Busy
    );
endinterface

// File: rtl/fetch_mem_responder.sv
// Memory-side responder: latches one request, waits WaitStates cycles,
// performs the read or write on the edge that enters ACK and holds Ack
// until the requester drops Req. The word array is never reset.
module fetch_mem_responder #(
    parameter int DataWidth  = 16,
    parameter int AddrWidth  = 8,
    parameter int WaitStates = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    fetch_mem_responder_if.slave      bus,
    output logic [1:0]                dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam int         DEPTH     = 1 << AddrWidth;
    localparam logic [3:0] WAIT_LOAD = 4'(WaitStates);
    localparam bit         ZERO_WAIT = (WaitStates == 0);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [3:0]           cnt;
    logic [AddrWidth-1:0] addr_q;
    logic                 wr_q;
    logic [DataWidth-1:0] data_q;
    logic [DataWidth-1:0] data_out;

    logic                 enter_ack;
    logic [AddrWidth-1:0] acc_addr;
    logic                 acc_wr;
    logic [DataWidth-1:0] acc_data;

    logic [DataWidth-1:0] mem [0:DEPTH-1];

    // Next state and the single-cycle "access now" strobe.
    always_comb begin
        state_nxt = state;
        enter_ack = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.Req) begin
                    if (ZERO_WAIT) begin
                        state_nxt = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.Req) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd1) begin
                    state_nxt = S_ACK;
                    enter_ack = 1'b1;
                end
            end
            S_ACK: begin
                if (!bus.Req) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the sampling edge itself,
    // before the latches hold the request, so take the live bus values then.
    always_comb begin
        if (state == S_IDLE) begin
            acc_addr = bus.Addr;
            acc_wr   = bus.WrEn;
            acc_data = bus.DataIn;
        end else begin
            acc_addr = addr_q;
            acc_wr   = wr_q;
            acc_data = data_q;
        end
    end

    // Control state, request latches, wait counter and read-data register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            data_q   <= '0;
            data_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.Req) begin
                addr_q <= bus.Addr;
                wr_q   <= bus.WrEn;
                data_q <= bus.DataIn;
                cnt    <= WAIT_LOAD;
            end else if (state == S_WAIT && bus.Req && cnt != 4'd1) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_ack && !acc_wr) begin
                data_out <= mem[acc_addr];
            end
        end
    end

    // Array write; contents survive reset by design.
    always_ff @(posedge Clk) begin
        if (enter_ack && acc_wr) begin
            mem[acc_addr] <= acc_data;
        end
    end

    assign bus.Ack     = (state == S_ACK);
    assign bus.Busy    = (state != S_IDLE);
    assign bus.DataOut = data_out;
    assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Bench for fetch_mem_responder: one instance with two wait states and one
// with none, both on a shared clock and reset, checked against a word-array
// model and the Req/Ack latency rule.
module tb_fetch_mem_responder;

    logic Clk;
    logic Reset;
    logic [1:0] dbg2;
    logic [1:0] dbg0;

    int total = 0;
    int bad   = 0;

    logic [15:0] mdl_mem  [2][256];
    logic [15:0] mdl_dout [2];

    fetch_mem_responder_if #(.DataWidth(16), .AddrWidth(8)) bus2 ();
    fetch_mem_responder_if #(.DataWidth(16), .AddrWidth(8)) bus0 ();

    fetch_mem_responder #(.DataWidth(16), .AddrWidth(8), .WaitStates(2)) u_ws2 (
        .Clk(Clk), .Reset(Reset), .bus(bus2), .dbg_state(dbg2)
    );

    fetch_mem_responder #(.DataWidth(16), .AddrWidth(8), .WaitStates(0)) u_ws0 (
        .Clk(Clk), .Reset(Reset), .bus(bus0), .dbg_state(dbg0)
    );

    // Clock and reset.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Driver helpers; z=1 selects the zero-wait instance.
    task automatic drive(input bit z, input logic req, input logic we,
                         input logic [7:0] a, input logic [15:0] d);
        if (z) begin
            bus0.Req = req; bus0.WrEn = we; bus0.Addr = a; bus0.DataIn = d;
        end else begin
            bus2.Req = req; bus2.WrEn = we; bus2.Addr = a; bus2.DataIn = d;
        end
    endtask

    function automatic logic get_ack(input bit z);
        return z ? bus0.Ack : bus2.Ack;
    endfunction

    function automatic logic get_busy(input bit z);
        return z ? bus0.Busy : bus2.Busy;
    endfunction

    function automatic logic [15:0] get_dout(input bit z);
        return z ? bus0.DataOut : bus2.DataOut;
    endfunction

    // Full transaction: request, count edges to Ack, scramble the bus after
    // the sampling edge, optionally hold Req in ACK, then release.
    task automatic do_txn(input bit z, input logic we, input logic [7:0] a,
                          input logic [15:0] d, input int hold);
        int   edges;
        logic acked;
        int   ws;
        ws    = z ? 0 : 2;
        edges = 0;
        acked = 1'b0;
        drive(z, 1'b1, we, a, d);
        while (!acked && edges < 40) begin
            tick();
            edges++;
            if (edges == 1) begin
                check("busy_after_e1", 32'(get_busy(z)), 32'd1);
                drive(z, 1'b1, 1'($urandom), 8'($urandom), 16'($urandom));
            end
            acked = get_ack(z);
        end
        check("ack_latency", 32'(edges), 32'(ws + 1));
        if (we) mdl_mem[z][a] = d;
        else    mdl_dout[z]   = mdl_mem[z][a];
        check("dout_at_ack", 32'(get_dout(z)), 32'(mdl_dout[z]));
        for (int i = 0; i < hold; i++) begin
            drive(z, 1'b1, 1'($urandom), 8'($urandom), 16'($urandom));
            tick();
            check("ack_held", 32'(get_ack(z)), 32'd1);
            check("dout_held", 32'(get_dout(z)), 32'(mdl_dout[z]));
        end
        drive(z, 1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        check("ack_release", 32'(get_ack(z)), 32'd0);
        check("busy_release", 32'(get_busy(z)), 32'd0);
    endtask

    // Abort a write on the two-wait instance after k edges in WAIT.
    task automatic abort_txn(input logic [7:0] a, input logic [15:0] d, input int k);
        drive(1'b0, 1'b1, 1'b1, a, d);
        for (int i = 0; i < k; i++) begin
            tick();
            check("abort_no_ack", 32'(bus2.Ack), 32'd0);
            check("abort_busy", 32'(bus2.Busy), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b1, a, d);
        tick();
        check("abort_ack", 32'(bus2.Ack), 32'd0);
        check("abort_idle", 32'(bus2.Busy), 32'd0);
        check("abort_dout", 32'(bus2.DataOut), 32'(mdl_dout[0]));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        Reset = 1'b1;
        mdl_dout[0] = 16'h0000;
        mdl_dout[1] = 16'h0000;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ack2",  32'(bus2.Ack),     32'd0);
        check("rst_busy2", 32'(bus2.Busy),    32'd0);
        check("rst_dout2", 32'(bus2.DataOut), 32'd0);
        check("rst_ack0",  32'(bus0.Ack),     32'd0);
        check("rst_busy0", 32'(bus0.Busy),    32'd0);
        check("rst_dout0", 32'(bus0.DataOut), 32'd0);
        Reset = 1'b0;
        tick();

        // Give every word a known value in both arrays.
        for (int a = 0; a < 256; a++) begin
            do_txn(1'b0, 1'b1, 8'(a), 16'($urandom), 0);
            do_txn(1'b1, 1'b1, 8'(a), 16'($urandom), 0);
        end

        // Write then read with two wait states.
        do_txn(1'b0, 1'b1, 8'h10, 16'hA55A, 0);
        do_txn(1'b0, 1'b0, 8'h10, 16'h0000, 0);
        check("wr_rd_a55a", 32'(bus2.DataOut), 32'h0000A55A);

        // Zero-wait instance.
        do_txn(1'b1, 1'b1, 8'h00, 16'h1234, 0);
        do_txn(1'b1, 1'b0, 8'h00, 16'h0000, 0);
        check("zw_1234", 32'(bus0.DataOut), 32'h00001234);

        // Top and bottom words stay distinct.
        for (int z = 0; z < 2; z++) begin
            do_txn(1'(z), 1'b1, 8'hFF, 16'hBEEF, 0);
            do_txn(1'(z), 1'b1, 8'h00, 16'h0001, 0);
            do_txn(1'(z), 1'b0, 8'hFF, 16'h0000, 0);
            check("boundary_ff", 32'(get_dout(1'(z))), 32'h0000BEEF);
        end

        // Abort in WAIT after one and after two edges.
        abort_txn(8'h20, 16'hDEAD, 2);
        abort_txn(8'h21, 16'hDEAD, 1);
        do_txn(1'b0, 1'b0, 8'h20, 16'h0000, 0);
        check("abort_kept_20", 32'(bus2.DataOut), 32'(mdl_mem[0][8'h20]));
        do_txn(1'b0, 1'b0, 8'h21, 16'h0000, 0);

        // Reset while a write sits in WAIT.
        drive(1'b0, 1'b1, 1'b1, 8'h30, 16'hCAFE);
        tick();
        #2;
        Reset = 1'b1;
        #1;
        check("rst_mid_ack",  32'(bus2.Ack),     32'd0);
        check("rst_mid_busy", 32'(bus2.Busy),    32'd0);
        check("rst_mid_dout", 32'(bus2.DataOut), 32'd0);
        check("rst_mid_dout0", 32'(bus0.DataOut), 32'd0);
        mdl_dout[0] = 16'h0000;
        mdl_dout[1] = 16'h0000;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        Reset = 1'b0;
        tick();
        do_txn(1'b0, 1'b0, 8'h30, 16'h0000, 0);
        check("rst_target_kept", 32'(bus2.DataOut), 32'(mdl_mem[0][8'h30]));
        do_txn(1'b0, 1'b0, 8'h10, 16'h0000, 0);
        check("rst_prev_kept", 32'(bus2.DataOut), 32'h0000A55A);

        // Req held high after Ack, with the bus changing underneath.
        do_txn(1'b0, 1'b1, 8'h40, 16'h7777, 5);
        do_txn(1'b0, 1'b0, 8'h40, 16'h0000, 5);
        do_txn(1'b1, 1'b1, 8'h41, 16'h8888, 5);
        do_txn(1'b1, 1'b0, 8'h41, 16'h0000, 5);

        // Random traffic on both instances, re-reading the whole array last.
        for (int n = 0; n < 300; n++) begin
            do_txn(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom),
                   $urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
                abort_txn(8'($urandom), 16'($urandom), $urandom_range(1, 2));
            end
        end
        for (int a = 0; a < 256; a++) begin
            do_txn(1'b0, 1'b0, 8'(a), 16'h0000, 0);
            do_txn(1'b1, 1'b0, 8'(a), 16'h0000, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
